// File: rtl/gd_pkg.sv
// Shared types and constants for the gradient-descent step sequencer:
// engine op codes, buffer ids, step/state encodings and float operands.
package gd_pkg;

    typedef enum logic [1:0] {
        OP_MATMUL = 2'd0,
        OP_SUB    = 2'd1,
        OP_SCALE  = 2'd2,
        OP_CLEAR  = 2'd3
    } op_e;

    localparam logic [3:0] BUF_X     = 4'd0;
    localparam logic [3:0] BUF_XT    = 4'd1;
    localparam logic [3:0] BUF_THETA = 4'd2;
    localparam logic [3:0] BUF_Y     = 4'd3;
    localparam logic [3:0] BUF_H     = 4'd4;
    localparam logic [3:0] BUF_HMY   = 4'd5;
    localparam logic [3:0] BUF_XTD   = 4'd6;
    localparam logic [3:0] BUF_G     = 4'd7;
    localparam logic [3:0] BUF_LG    = 4'd8;

    // IEEE-754 single: 1/M for M=100, and the learning rate.
    localparam logic [31:0] ONE_DIV_M_F = 32'h3C23D70A;
    localparam logic [31:0] LR_F        = 32'h38D1B717;

    typedef enum logic [2:0] {
        STEP_CLR = 3'd0,
        STEP_S1  = 3'd1,
        STEP_S2  = 3'd2,
        STEP_S3  = 3'd3,
        STEP_S4  = 3'd4,
        STEP_S5  = 3'd5,
        STEP_S6  = 3'd6
    } step_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT_RES = 3'd2,
        ST_NEXT     = 3'd3,
        ST_DUMP     = 3'd4,
        ST_ERR      = 3'd5
    } state_e;

    typedef struct packed {
        op_e         code;
        logic [3:0]  src_a;
        logic [3:0]  src_b;
        logic [3:0]  dst;
        logic [31:0] scalar;
    } op_t;

endpackage

// File: rtl/gd_step_rom.sv
// Combinational step table: maps a sequencer step to the engine operation,
// its source/destination buffers and the scalar operand.
module gd_step_rom
    import gd_pkg::*;
#(
    parameter logic [31:0] ONE_DIV_M = ONE_DIV_M_F,
    parameter logic [31:0] LR        = LR_F
) (
    input  step_e i_step,
    output op_t   o_op
);

    // NOTE: the all-zero default first keeps this block latch-free and makes
    // unused source ids and non-SCALE scalars read as 0.
    always_comb begin
        o_op = '0;
        case (i_step)
            STEP_CLR: begin
                o_op.code = OP_CLEAR;
                o_op.dst  = BUF_THETA;
            end
            STEP_S1: begin
                o_op.code  = OP_MATMUL;
                o_op.src_a = BUF_X;
                o_op.src_b = BUF_THETA;
                o_op.dst   = BUF_H;
            end
            STEP_S2: begin
                o_op.code  = OP_SUB;
                o_op.src_a = BUF_H;
                o_op.src_b = BUF_Y;
                o_op.dst   = BUF_HMY;
            end
            STEP_S3: begin
                o_op.code   = OP_SCALE;
                o_op.src_a  = BUF_XT;
                o_op.dst    = BUF_XTD;
                o_op.scalar = ONE_DIV_M;
            end
            STEP_S4: begin
                o_op.code  = OP_MATMUL;
                o_op.src_a = BUF_XTD;
                o_op.src_b = BUF_HMY;
                o_op.dst   = BUF_G;
            end
            STEP_S5: begin
                o_op.code   = OP_SCALE;
                o_op.src_a  = BUF_G;
                o_op.dst    = BUF_LG;
                o_op.scalar = LR;
            end
            STEP_S6: begin
                o_op.code  = OP_SUB;
                o_op.src_a = BUF_THETA;
                o_op.src_b = BUF_LG;
                o_op.dst   = BUF_THETA;
            end
            default: o_op = '0;
        endcase
    end

endmodule

// File: rtl/gd_step_sequencer.sv
// Drives the shared matrix engine through the batch gradient-descent loop,
// with a result watchdog, iteration counting and a final Theta dump.
module gd_step_sequencer
    import gd_pkg::*;
#(
    parameter int          MAX_ITER  = 2000,
    parameter int          ITER_W    = 11,
    parameter int          TIMEOUT   = 2**24,
    parameter logic [31:0] ONE_DIV_M = ONE_DIV_M_F,
    parameter logic [31:0] LR        = LR_F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              batch_ready,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ITER_W-1:0] iter_count,
    output logic              op_stb,
    input  logic              op_ack,
    output logic [1:0]        op_code,
    output logic [3:0]        op_src_a,
    output logic [3:0]        op_src_b,
    output logic [3:0]        op_dst,
    output logic [31:0]       op_scalar,
    input  logic              res_stb,
    output logic              res_ack,
    output logic              dump_req,
    input  logic              dump_done
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_e            r_state;
    step_e             r_step;
    logic              r_first;
    logic [WD_W-1:0]   r_wd;
    logic [ITER_W-1:0] r_iter;
    logic              r_busy, r_done, r_error, r_op_stb, r_res_ack, r_dump_req;
    op_t               r_op;

    step_e             w_rom_step;
    op_t               w_op;

    // Step about to be issued: CLR when launching a run, else the successor.
    always_comb begin
        w_rom_step = STEP_CLR;
        if (r_state == ST_NEXT) begin
            case (r_step)
                STEP_CLR: w_rom_step = STEP_S1;
                STEP_S1:  w_rom_step = STEP_S2;
                STEP_S2:  w_rom_step = r_first ? STEP_S3 : STEP_S4;
                STEP_S3:  w_rom_step = STEP_S4;
                STEP_S4:  w_rom_step = STEP_S5;
                STEP_S5:  w_rom_step = STEP_S6;
                STEP_S6:  w_rom_step = STEP_S1;
                default:  w_rom_step = STEP_CLR;
            endcase
        end
    end

    gd_step_rom #(
        .ONE_DIV_M (ONE_DIV_M),
        .LR        (LR)
    ) u_rom (
        .i_step (w_rom_step),
        .o_op   (w_op)
    );

    // NOTE: sequential state uses non-blocking assignments only, and the reset
    // is synchronous, so rst is sampled on clk like any other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_step     <= STEP_CLR;
            r_first    <= 1'b0;
            r_wd       <= '0;
            r_iter     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_op_stb   <= 1'b0;
            r_res_ack  <= 1'b0;
            r_dump_req <= 1'b0;
            r_op       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_ERR: begin
                    if (start && batch_ready) begin
                        r_state  <= ST_ISSUE;
                        r_step   <= STEP_CLR;
                        r_iter   <= '0;
                        r_first  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_error  <= 1'b0;
                        r_op_stb <= 1'b1;
                        r_op     <= w_op;
                    end
                end
                ST_ISSUE: begin
                    if (op_ack) begin
                        r_op_stb  <= 1'b0;
                        r_res_ack <= 1'b1;
                        r_wd      <= '0;
                        r_state   <= ST_WAIT_RES;
                    end
                end
                ST_WAIT_RES: begin
                    if (res_stb) begin
                        r_res_ack <= 1'b0;
                        r_state   <= ST_NEXT;
                    end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
                        r_state   <= ST_ERR;
                        r_error   <= 1'b1;
                        r_busy    <= 1'b0;
                        r_res_ack <= 1'b0;
                        r_op_stb  <= 1'b0;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                ST_NEXT: begin
                    if (r_step == STEP_S6) begin
                        r_iter <= r_iter + 1'b1;
                    end
                    if (r_step == STEP_S6 && r_iter == ITER_W'(MAX_ITER - 1)) begin
                        r_dump_req <= 1'b1;
                        r_state    <= ST_DUMP;
                    end else begin
                        if (r_step == STEP_S3) begin
                            r_first <= 1'b0;
                        end
                        r_step   <= w_rom_step;
                        r_op     <= w_op;
                        r_op_stb <= 1'b1;
                        r_state  <= ST_ISSUE;
                    end
                end
                ST_DUMP: begin
                    if (dump_done) begin
                        r_dump_req <= 1'b0;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign iter_count = r_iter;
    assign op_stb     = r_op_stb;
    assign op_code    = r_op.code;
    assign op_src_a   = r_op.src_a;
    assign op_src_b   = r_op.src_b;
    assign op_dst     = r_op.dst;
    assign op_scalar  = r_op.scalar;
    assign res_ack    = r_res_ack;
    assign dump_req   = r_dump_req;

endmodule
